camera_gray_feeder: RTL and testbench

Front-end stage between the synchronized camera byte interface and the Sobel accelerator. Pairs incoming RGB565 bytes into pixels, converts each pixel to 8-bit luminance in a two-stage pipeline, and emits the camData / validCamera / hsync / vsync stream the Sobel stage consumes. Also measures line length and frame height for software readback.

---
 rtl/camera_gray_feeder.sv | 196 +++++++++++++++++++
 tb/tb_camera_gray_feeder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_gray_feeder.sv
// RGB565 byte pairing, two-stage luminance pipeline and line/frame measurement for the Sobel front end.
// Optional 2:1 horizontal decimation is enabled by defining GRAY_DECIMATE_EN.
module camera_gray_feeder (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  camByte,
  input  logic        camByteValid,
  input  logic        camHref,
  input  logic        camVsync,
  output logic [7:0]  camData,
  output logic        validCamera,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] pixelsPerLine,
  output logic [9:0]  linesPerFrame,
  output logic        byteError,
  output logic        frameActive
);

  typedef enum logic {
    ST_HIGH = 1'b0,
    ST_LOW  = 1'b1
  } state_t;

  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  logic        r_href_d;
  logic        r_vs_d;
  logic        w_href_fall;
  logic        w_vs_rise;
  state_t      r_state;
  logic [7:0]  r_hi;
  logic        w_pix_asm;
  logic        w_pix_take;
  logic [15:0] w_pix;
  logic [7:0]  w_r8;
  logic [7:0]  w_g8;
  logic [7:0]  w_b8;
  logic        r_s1_valid;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic [15:0] r_mul_r;
  logic [15:0] r_mul_g;
  logic [15:0] r_mul_b;
  logic [7:0]  w_gray;
  logic [10:0] r_pix_cnt;
  logic [9:0]  r_line_cnt;
  logic        w_line_inc;
  logic [9:0]  w_lines_next;
`ifdef GRAY_DECIMATE_EN
  logic        r_phase;
`endif

  assign w_href_fall = r_href_d & ~camHref;
  assign w_vs_rise   = ~r_vs_d & camVsync;
  assign w_pix       = {r_hi, camByte};
  assign w_r8        = expand5(w_pix[15:11]);
  assign w_g8        = expand6(w_pix[10:5]);
  assign w_b8        = expand5(w_pix[4:0]);
  // Coefficients sum to 256, so the top byte of the 16-bit sum is the luminance.
  assign w_gray      = 8'((r_mul_r + r_mul_g + r_mul_b) >> 8);

  always_comb begin
    w_pix_asm  = 1'b0;
    w_pix_take = 1'b0;
    if ((r_state == ST_LOW) && camByteValid && camHref && !w_href_fall && !w_vs_rise) begin
      w_pix_asm = 1'b1;
    end else begin
      w_pix_asm = 1'b0;
    end
`ifdef GRAY_DECIMATE_EN
    w_pix_take = w_pix_asm & frameActive & ~r_phase;
`else
    w_pix_take = w_pix_asm & frameActive;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_href_d    <= 1'b0;
      r_vs_d      <= 1'b0;
      frameActive <= 1'b0;
    end else begin
      r_href_d <= camHref;
      r_vs_d   <= camVsync;
      if (w_vs_rise) begin
        frameActive <= enable;
      end
    end
  end

  // Byte pairing: a line or frame boundary always restarts on the high byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_HIGH;
      r_hi      <= 8'd0;
      byteError <= 1'b0;
    end else if (w_href_fall || w_vs_rise) begin
      if (w_href_fall && (r_state == ST_LOW)) begin
        byteError <= 1'b1;
      end
      r_state <= ST_HIGH;
    end else if (camByteValid && camHref) begin
      case (r_state)
        ST_HIGH: begin
          r_hi    <= camByte;
          r_state <= ST_LOW;
        end
        ST_LOW:  r_state <= ST_HIGH;
        default: r_state <= ST_HIGH;
      endcase
    end
  end

`ifdef GRAY_DECIMATE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase <= 1'b0;
    end else if (w_href_fall || w_vs_rise) begin
      r_phase <= 1'b0;
    end else if (w_pix_asm) begin
      r_phase <= ~r_phase;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_mul_r    <= 16'd0;
      r_mul_g    <= 16'd0;
      r_mul_b    <= 16'd0;
    end else begin
      r_s1_valid <= w_pix_take;
      r_s1_hs    <= w_href_fall & frameActive;
      r_s1_vs    <= w_vs_rise;
      if (w_pix_take) begin
        r_mul_r <= 16'd77  * {8'd0, w_r8};
        r_mul_g <= 16'd150 * {8'd0, w_g8};
        r_mul_b <= 16'd29  * {8'd0, w_b8};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      validCamera <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      camData     <= 8'd0;
    end else begin
      validCamera <= r_s1_valid;
      hsync       <= r_s1_hs;
      vsync       <= r_s1_vs;
      if (r_s1_valid) begin
        camData <= w_gray;
      end
    end
  end

  // A line closing in the same cycle as a frame start is folded into that frame's count.
  assign w_line_inc   = w_href_fall && (r_pix_cnt != 11'd0);
  assign w_lines_next = (w_line_inc && (r_line_cnt != 10'h3FF)) ? (r_line_cnt + 10'd1) : r_line_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pix_cnt     <= 11'd0;
      r_line_cnt    <= 10'd0;
      pixelsPerLine <= 11'd0;
      linesPerFrame <= 10'd0;
    end else begin
      if (w_href_fall) begin
        pixelsPerLine <= r_pix_cnt;
        r_pix_cnt     <= 11'd0;
      end else if (w_pix_take && (r_pix_cnt != 11'h7FF)) begin
        r_pix_cnt <= r_pix_cnt + 11'd1;
      end
      if (w_vs_rise) begin
        linesPerFrame <= w_lines_next;
        r_line_cnt    <= 10'd0;
      end else begin
        r_line_cnt <= w_lines_next;
      end
    end
  end

endmodule

// File: tb/tb_camera_gray_feeder.sv
// Scoreboard bench for camera_gray_feeder: expected pixels/syncs are queued with their due cycle.
module tb_camera_gray_feeder;

`ifdef GRAY_DECIMATE_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  camByte;
  logic        camByteValid;
  logic        camHref;
  logic        camVsync;
  logic [7:0]  camData;
  logic        validCamera;
  logic        hsync;
  logic        vsync;
  logic [10:0] pixelsPerLine;
  logic [9:0]  linesPerFrame;
  logic        byteError;
  logic        frameActive;

  camera_gray_feeder dut (
    .clock(clock), .reset(reset), .enable(enable), .camByte(camByte),
    .camByteValid(camByteValid), .camHref(camHref), .camVsync(camVsync),
    .camData(camData), .validCamera(validCamera), .hsync(hsync), .vsync(vsync),
    .pixelsPerLine(pixelsPerLine), .linesPerFrame(linesPerFrame),
    .byteError(byteError), .frameActive(frameActive)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] d;
  } pix_t;

  pix_t pq[$];
  int   hq[$];
  int   vq[$];
  logic [15:0] line_px[$];

  int checks = 0;
  int failures = 0;

  logic       m_href_prev, m_vs_prev, m_low, m_fa, m_phase;
  logic [7:0] m_hi;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gray_of(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8, s;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    s  = 77 * r8 + 150 * g8 + 29 * b8;
    return s[15:8];
  endfunction

  function automatic int exp_ppl(input int n);
    return DECIM ? (n + 1) / 2 : n;
  endfunction

  task automatic model_reset();
    m_href_prev = 1'b0;
    m_vs_prev   = 1'b0;
    m_low       = 1'b0;
    m_fa        = 1'b0;
    m_phase     = 1'b0;
    m_hi        = 8'd0;
    pq.delete();
    hq.delete();
    vq.delete();
  endtask

  // Drive one cycle of camera inputs and record what the DUT owes two cycles later.
  task automatic step(input logic [7:0] b, input logic v, input logic h, input logic vs);
    logic hf, vr;
    camByte = b; camByteValid = v; camHref = h; camVsync = vs;
    hf = m_href_prev & ~h;
    vr = ~m_vs_prev & vs;
    if (vr) vq.push_back(cyc + 2);
    if (hf && m_fa) hq.push_back(cyc + 2);
    if (hf || vr) begin
      m_low = 1'b0;
      m_phase = 1'b0;
    end else if (v && h) begin
      if (!m_low) begin
        m_hi = b;
        m_low = 1'b1;
      end else begin
        m_low = 1'b0;
        if (m_fa && (!DECIM || !m_phase)) pq.push_back(pix_t'{c: cyc + 2, d: gray_of({m_hi, b})});
        if (DECIM) m_phase = ~m_phase;
      end
    end
    if (vr) m_fa = enable;
    m_href_prev = h;
    m_vs_prev = vs;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vs_pulse();
    step(8'd0, 1'b0, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_line(input bit gaps, input bit end_vs);
    foreach (line_px[i]) begin
      step(line_px[i][15:8], 1'b1, 1'b1, 1'b0);
      if (gaps) step(8'h5A, 1'b0, 1'b1, 1'b0);
      step(line_px[i][7:0], 1'b1, 1'b1, 1'b0);
    end
    step(8'd0, 1'b0, 1'b0, end_vs);
    if (end_vs) step(8'd0, 1'b0, 1'b0, 1'b0);
    idle(3);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_camData"}, camData, 8'd0);
    check_eq({tag, "_valid"}, validCamera, 1'b0);
    check_eq({tag, "_hsync"}, hsync, 1'b0);
    check_eq({tag, "_vsync"}, vsync, 1'b0);
    check_eq({tag, "_ppl"}, pixelsPerLine, 11'd0);
    check_eq({tag, "_lpf"}, linesPerFrame, 10'd0);
    check_eq({tag, "_byteErr"}, byteError, 1'b0);
    check_eq({tag, "_frameAct"}, frameActive, 1'b0);
  endtask

  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      while (pq.size() > 0 && pq[0].c < cyc) begin
        check_eq("pix_missing_at", cyc, pq[0].c);
        pq.delete(0);
      end
      while (hq.size() > 0 && hq[0] < cyc) begin
        check_eq("hsync_missing_at", cyc, hq[0]);
        hq.delete(0);
      end
      while (vq.size() > 0 && vq[0] < cyc) begin
        check_eq("vsync_missing_at", cyc, vq[0]);
        vq.delete(0);
      end
      if (validCamera) begin
        if (pq.size() == 0) check_eq("pix_extra", 1, 0);
        else begin
          check_eq("pix_lat", cyc, pq[0].c);
          check_eq("pix_data", camData, pq[0].d);
          pq.delete(0);
        end
      end
      if (hsync) begin
        if (hq.size() == 0) check_eq("hsync_extra", 1, 0);
        else begin
          check_eq("hsync_lat", cyc, hq[0]);
          hq.delete(0);
        end
      end
      if (vsync) begin
        if (vq.size() == 0) check_eq("vsync_extra", 1, 0);
        else begin
          check_eq("vsync_lat", cyc, vq[0]);
          vq.delete(0);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b0; camByte = 8'd0; camByteValid = 1'b0;
    camHref = 1'b0; camVsync = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Frame forwarding, white line
    enable = 1'b1;
    vs_pulse();
    check_eq("frameActive_on", frameActive, 1'b1);
    line_px = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    send_line(1'b0, 1'b0);
    check_eq("ppl_white", pixelsPerLine, 11'(exp_ppl(4)));

    // Primary colours with idle gaps between bytes
    line_px = '{16'hF800, 16'h07E0, 16'h001F};
    send_line(1'b1, 1'b0);
    check_eq("ppl_rgb", pixelsPerLine, 11'(exp_ppl(3)));
    check_eq("byteErr_clean", byteError, 1'b0);

    // Odd byte count: five bytes
    step(8'h12, 1'b1, 1'b1, 1'b0);
    step(8'h34, 1'b1, 1'b1, 1'b0);
    step(8'h56, 1'b1, 1'b1, 1'b0);
    step(8'h78, 1'b1, 1'b1, 1'b0);
    step(8'h9A, 1'b1, 1'b1, 1'b0);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("byteErr_set", byteError, 1'b1);
    check_eq("ppl_odd", pixelsPerLine, 11'(exp_ppl(2)));

    vs_pulse();
    idle(2);
    check_eq("lpf_three", linesPerFrame, 10'd3);
    line_px = '{16'h1234, 16'h8421};
    send_line(1'b0, 1'b0);
    check_eq("byteErr_sticky", byteError, 1'b1);

    // Disabled frame; enable raised mid-frame has no effect
    enable = 1'b0;
    vs_pulse();
    check_eq("frameActive_off", frameActive, 1'b0);
    check_eq("lpf_one", linesPerFrame, 10'd1);
    line_px = '{16'hFFFF, 16'h0000, 16'hAAAA};
    send_line(1'b0, 1'b0);
    enable = 1'b1;
    send_line(1'b0, 1'b0);
    check_eq("frameActive_still_off", frameActive, 1'b0);
    check_eq("ppl_disabled", pixelsPerLine, 11'd0);
    vs_pulse();
    check_eq("frameActive_back", frameActive, 1'b1);
    check_eq("lpf_disabled", linesPerFrame, 10'd0);

    // Three 640-pixel lines; the last closes in the same cycle as the frame start
    for (int ln = 0; ln < 3; ln++) begin
      line_px.delete();
      for (int p = 0; p < 640; p++) line_px.push_back(16'($urandom));
      send_line(1'b0, ln == 2);
    end
    check_eq("lpf_640", linesPerFrame, 10'd3);
    check_eq("ppl_640", pixelsPerLine, 11'(exp_ppl(640)));

    // Asynchronous reset in the middle of a line
    step(8'hFF, 1'b1, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b1, 1'b0);
    step(8'hF8, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    #1 check_all_zero("midreset");
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    line_px = '{16'hFFFF, 16'h07E0};
    send_line(1'b0, 1'b0);
    check_eq("frameActive_after_rst", frameActive, 1'b0);
    vs_pulse();
    line_px = '{16'h1234, 16'hABCD};
    send_line(1'b0, 1'b0);
    check_eq("ppl_after_rst", pixelsPerLine, 11'(exp_ppl(2)));

    idle(5);
    check_eq("pix_pending", pq.size(), 0);
    check_eq("hsync_pending", hq.size(), 0);
    check_eq("vsync_pending", vq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
